// File: rtl/sys_cmd_if.sv
// sys_cmd_if: command request, UART byte and response signals
// shared by sys_cmd_master (master) and its host/UART side (slave).
interface sys_cmd_if;
  logic       CMD_VLD;
  logic       CMD_RDY;
  logic [1:0] CMD_TYPE;
  logic [3:0] CMD_ADDR;
  logic [7:0] CMD_DATA;
  logic [7:0] CMD_OPA;
  logic [7:0] CMD_OPB;
  logic [3:0] CMD_FUN;
  logic [7:0] TX_P_DATA;
  logic       TX_D_VLD;
  logic       Busy;
  logic [7:0] RX_P_DATA;
  logic       RX_D_VLD;
  logic [7:0] RSP_DATA;
  logic       RSP_VLD;
  logic       RSP_TIMEOUT;

  modport master (
    input  CMD_VLD, CMD_TYPE, CMD_ADDR,
    input  CMD_DATA, CMD_OPA, CMD_OPB,
    input  CMD_FUN, Busy,
    input  RX_P_DATA, RX_D_VLD,
    output CMD_RDY, TX_P_DATA, TX_D_VLD,
    output RSP_DATA, RSP_VLD, RSP_TIMEOUT
  );

  modport slave (
    output CMD_VLD, CMD_TYPE, CMD_ADDR,
    output CMD_DATA, CMD_OPA, CMD_OPB,
    output CMD_FUN, Busy,
    output RX_P_DATA, RX_D_VLD,
    input  CMD_RDY, TX_P_DATA, TX_D_VLD,
    input  RSP_DATA, RSP_VLD, RSP_TIMEOUT
  );
endinterface

// File: rtl/sys_cmd_master.sv
// sys_cmd_master: host-side command framer for the UART system-controller
// link; sends one command frame and collects the single response byte.
module sys_cmd_master #(
  parameter int TIMEOUT_CYC = 65535
) (
  input logic       CLK,
  input logic       RST,
  sys_cmd_if.master bus
);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] LIM = CW'(TIMEOUT_CYC - 1);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] SEND     = 3'd1;
  localparam logic [2:0] WAIT_HI  = 3'd2;
  localparam logic [2:0] WAIT_LO  = 3'd3;
  localparam logic [2:0] WAIT_RSP = 3'd4;

  logic [2:0]      state;
  logic [3:0][7:0] frame;
  logic [3:0][7:0] nxt_frame;
  logic [2:0]      len;
  logic [2:0]      nxt_len;
  logic            need_rsp;
  logic            nxt_rsp;
  logic [1:0]      idx;
  logic [CW-1:0]   cnt;
  logic            last;
  logic [7:0]      tx_data;
  logic            tx_vld;
  logic [7:0]      rsp_data;
  logic            rsp_vld;
  logic            rsp_to;

  assign last = (({1'b0, idx}) + 3'd1) == len;

  assign bus.CMD_RDY     = (state == IDLE);
  assign bus.TX_P_DATA   = tx_data;
  assign bus.TX_D_VLD    = tx_vld;
  assign bus.RSP_DATA    = rsp_data;
  assign bus.RSP_VLD     = rsp_vld;
  assign bus.RSP_TIMEOUT = rsp_to;

  // Frame image built from the live request; captured only on accept.
  always_comb begin
    nxt_frame = '0;
    nxt_len   = 3'd2;
    nxt_rsp   = 1'b1;
    unique case (bus.CMD_TYPE)
      2'd0: begin
        nxt_frame[0] = 8'hAA;
        nxt_frame[1] = {4'h0, bus.CMD_ADDR};
        nxt_frame[2] = bus.CMD_DATA;
        nxt_len      = 3'd3;
        nxt_rsp      = 1'b0;
      end
      2'd1: begin
        nxt_frame[0] = 8'hBB;
        nxt_frame[1] = {4'h0, bus.CMD_ADDR};
      end
      2'd2: begin
        nxt_frame[0] = 8'hCC;
        nxt_frame[1] = bus.CMD_OPA;
        nxt_frame[2] = bus.CMD_OPB;
        nxt_frame[3] = {4'h0, bus.CMD_FUN};
        nxt_len      = 3'd4;
      end
      2'd3: begin
        nxt_frame[0] = 8'hDD;
        nxt_frame[1] = {4'h0, bus.CMD_FUN};
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= IDLE;
      frame    <= '0;
      len      <= 3'd2;
      need_rsp <= 1'b0;
      idx      <= 2'd0;
      cnt      <= '0;
      tx_data  <= 8'h00;
      tx_vld   <= 1'b0;
      rsp_data <= 8'h00;
      rsp_vld  <= 1'b0;
      rsp_to   <= 1'b0;
    end else begin
      tx_vld  <= 1'b0;
      rsp_vld <= 1'b0;
      rsp_to  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.CMD_VLD) begin
            frame    <= nxt_frame;
            len      <= nxt_len;
            need_rsp <= nxt_rsp;
            idx      <= 2'd0;
            state    <= SEND;
          end
        end
        SEND: begin
          if (!bus.Busy) begin
            tx_data <= frame[idx];
            tx_vld  <= 1'b1;
            state   <= WAIT_HI;
          end
        end
        WAIT_HI: begin
          if (bus.Busy) state <= WAIT_LO;
        end
        WAIT_LO: begin
          if (!bus.Busy) begin
            idx <= idx + 2'd1;
            cnt <= '0;
            if (!last) state <= SEND;
            else if (need_rsp) state <= WAIT_RSP;
            else state <= IDLE;
          end
        end
        WAIT_RSP: begin
          // A response in the final cycle takes priority over the timeout.
          if (bus.RX_D_VLD) begin
            rsp_data <= bus.RX_P_DATA;
            rsp_vld  <= 1'b1;
            state    <= IDLE;
          end else if (cnt == LIM) begin
            rsp_to <= 1'b1;
            state  <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sys_cmd_master.sv
// tb_sys_cmd_master: directed scoreboard bench for sys_cmd_master,
// one default instance and one with a 16-cycle response timeout.
module tb_sys_cmd_master;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       vld_a;
  logic       vld_b;
  logic [1:0] cmd_type;
  logic [3:0] cmd_addr;
  logic [3:0] cmd_fun;
  logic [7:0] cmd_data;
  logic [7:0] cmd_opa;
  logic [7:0] cmd_opb;
  logic       busy;
  logic [7:0] rx_data;
  logic       rx_vld;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int falls = 0;
  int fall_cyc = 0;
  int rsp_cyc = 0;
  int tx_cyc = 0;
  int n_tx = 0;
  int acc_cyc = 0;
  int bcnt = 0;
  int busy_len = 3;
  int base = 0;

  logic [7:0] exp_tx[$];
  logic [8:0] exp_rsp[$];

  sys_cmd_if ia();
  sys_cmd_if ib();

  assign ia.CMD_VLD   = vld_a;
  assign ia.CMD_TYPE  = cmd_type;
  assign ia.CMD_ADDR  = cmd_addr;
  assign ia.CMD_DATA  = cmd_data;
  assign ia.CMD_OPA   = cmd_opa;
  assign ia.CMD_OPB   = cmd_opb;
  assign ia.CMD_FUN   = cmd_fun;
  assign ia.Busy      = busy;
  assign ia.RX_P_DATA = rx_data;
  assign ia.RX_D_VLD  = rx_vld;
  assign ib.CMD_VLD   = vld_b;
  assign ib.CMD_TYPE  = cmd_type;
  assign ib.CMD_ADDR  = cmd_addr;
  assign ib.CMD_DATA  = cmd_data;
  assign ib.CMD_OPA   = cmd_opa;
  assign ib.CMD_OPB   = cmd_opb;
  assign ib.CMD_FUN   = cmd_fun;
  assign ib.Busy      = busy;
  assign ib.RX_P_DATA = rx_data;
  assign ib.RX_D_VLD  = rx_vld;

  sys_cmd_master dut (
    .CLK (clk),
    .RST (rst_n),
    .bus (ia.master)
  );

  sys_cmd_master #(.TIMEOUT_CYC(16)) dut_t (
    .CLK (clk),
    .RST (rst_n),
    .bus (ib.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic got_tx(input logic [7:0] b, input string tag);
    logic [7:0] e;
    n_tx++;
    tx_cyc = cyc;
    if (exp_tx.size() == 0) e = ~b;
    else e = exp_tx.pop_front();
    chk(tag, 32'(b), 32'(e));
  endtask

  task automatic got_rsp(input logic [8:0] v, input string tag);
    logic [8:0] e;
    rsp_cyc = cyc;
    if (exp_rsp.size() == 0) e = v ^ 9'h100;
    else e = exp_rsp.pop_front();
    chk(tag, 32'(v), 32'(e));
  endtask

  // One cycle: sample DUT strobes, then advance the UART busy model.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (ia.TX_D_VLD) got_tx(ia.TX_P_DATA, "tx_a");
    if (ib.TX_D_VLD) got_tx(ib.TX_P_DATA, "tx_b");
    if (ia.RSP_VLD) got_rsp({1'b0, ia.RSP_DATA}, "rsp_a");
    if (ia.RSP_TIMEOUT) got_rsp({1'b1, ia.RSP_DATA}, "tmo_a");
    if (ib.RSP_VLD) got_rsp({1'b0, ib.RSP_DATA}, "rsp_b");
    if (ib.RSP_TIMEOUT) got_rsp({1'b1, ib.RSP_DATA}, "tmo_b");
    if (busy) begin
      bcnt--;
      if (bcnt <= 0) begin
        busy = 1'b0;
        falls++;
        fall_cyc = cyc;
      end
    end
    if (ia.TX_D_VLD || ib.TX_D_VLD) begin
      busy = 1'b1;
      bcnt = busy_len;
    end
  endtask

  function automatic logic rdy(input bit b);
    return b ? ib.CMD_RDY : ia.CMD_RDY;
  endfunction

  task automatic wait_rdy(input bit b, input string tag);
    int n = 0;
    while (!rdy(b) && n < 2000) begin
      tick();
      n++;
    end
    if (!rdy(b)) chk({tag, "_rdy_wait"}, 32'(rdy(b)), 32'd1);
  endtask

  task automatic wait_falls(input int target);
    int n = 0;
    while (falls < target && n < 2000) begin
      tick();
      n++;
    end
    if (falls < target) chk("busy_fall_wait", 32'(falls), 32'(target));
  endtask

  task automatic chk_reset(input string tag, input bit b);
    logic [19:0] o;
    if (b) o = {ib.CMD_RDY, ib.TX_P_DATA, ib.TX_D_VLD,
                ib.RSP_DATA, ib.RSP_VLD, ib.RSP_TIMEOUT};
    else o = {ia.CMD_RDY, ia.TX_P_DATA, ia.TX_D_VLD,
              ia.RSP_DATA, ia.RSP_VLD, ia.RSP_TIMEOUT};
    chk(tag, 32'(o), 32'h80000);
  endtask

  task automatic rx_pulse(input logic [7:0] d);
    rx_data = d;
    rx_vld  = 1'b1;
    tick();
    rx_vld  = 1'b0;
  endtask

  task automatic send_cmd(input bit b, input logic [1:0] t,
                          input logic [3:0] a, input logic [7:0] d,
                          input logic [7:0] oa, input logic [7:0] ob,
                          input logic [3:0] f);
    wait_rdy(b, "pre_accept");
    case (t)
      2'd0: begin
        exp_tx.push_back(8'hAA);
        exp_tx.push_back({4'h0, a});
        exp_tx.push_back(d);
      end
      2'd1: begin
        exp_tx.push_back(8'hBB);
        exp_tx.push_back({4'h0, a});
      end
      2'd2: begin
        exp_tx.push_back(8'hCC);
        exp_tx.push_back(oa);
        exp_tx.push_back(ob);
        exp_tx.push_back({4'h0, f});
      end
      default: begin
        exp_tx.push_back(8'hDD);
        exp_tx.push_back({4'h0, f});
      end
    endcase
    cmd_type = t;
    cmd_addr = a;
    cmd_data = d;
    cmd_opa  = oa;
    cmd_opb  = ob;
    cmd_fun  = f;
    if (b) vld_b = 1'b1;
    else vld_a = 1'b1;
    tick();
    acc_cyc = cyc;
    vld_a = 1'b0;
    vld_b = 1'b0;
    cmd_type = ~t;
    cmd_addr = ~a;
    cmd_data = ~d;
    cmd_opa  = ~oa;
    cmd_opb  = ~ob;
    cmd_fun  = ~f;
    chk("rdy_low_after_accept", 32'(rdy(b)), 32'd0);
  endtask

  initial begin
    int n;
    vld_a = 1'b0;
    vld_b = 1'b0;
    cmd_type = 2'd0;
    cmd_addr = 4'h0;
    cmd_fun  = 4'h0;
    cmd_data = 8'h00;
    cmd_opa  = 8'h00;
    cmd_opb  = 8'h00;
    busy     = 1'b0;
    rx_data  = 8'h00;
    rx_vld   = 1'b0;
    repeat (3) tick();
    chk_reset("reset_a", 1'b0);
    chk_reset("reset_b", 1'b1);
    rst_n = 1'b1;
    tick();

    // REG_WR, slow transmitter, no response expected
    busy_len = 10;
    base = falls;
    send_cmd(1'b0, 2'd0, 4'h5, 8'h3C, 8'h00, 8'h00, 4'h0);
    wait_rdy(1'b0, "t1");
    chk("t1_busy_falls", 32'(falls - base), 32'd3);
    chk("t1_rdy_lag", 32'(cyc - fall_cyc), 32'd1);

    // REG_RD with reply 20 cycles after the last byte
    busy_len = 3;
    base = falls;
    exp_rsp.push_back({1'b0, 8'h7E});
    send_cmd(1'b0, 2'd1, 4'h2, 8'h00, 8'h00, 8'h00, 4'h0);
    wait_falls(base + 2);
    repeat (20) tick();
    rx_pulse(8'h7E);
    wait_rdy(1'b0, "t2");
    chk("t2_rdy_lag", 32'(cyc - rsp_cyc), 32'd0);
    repeat (3) tick();
    chk("t2_rsp_hold", 32'(ia.RSP_DATA), 32'h7E);

    // ALU_OPS then ALU_NOOP back-to-back
    base = falls;
    exp_rsp.push_back({1'b0, 8'h46});
    send_cmd(1'b0, 2'd2, 4'h0, 8'h00, 8'h12, 8'h34, 4'h1);
    wait_falls(base + 4);
    repeat (5) tick();
    rx_pulse(8'h46);
    wait_rdy(1'b0, "t3a");
    chk("t3_rdy_lag", 32'(cyc - rsp_cyc), 32'd0);
    base = falls;
    exp_rsp.push_back({1'b0, 8'h5A});
    send_cmd(1'b0, 2'd3, 4'h0, 8'h00, 8'h00, 8'h00, 4'h3);
    chk("t3_b2b_gap", 32'(acc_cyc - rsp_cyc), 32'd1);
    tick();
    chk("t3_tx_latency", 32'(tx_cyc - acc_cyc), 32'd1);
    wait_falls(base + 2);
    repeat (2) tick();
    rx_pulse(8'h5A);
    wait_rdy(1'b0, "t3b");
    chk("t3_rsp_data", 32'(ia.RSP_DATA), 32'h5A);

    // 16-cycle timeout instance: reply, timeout, final-cycle reply
    base = falls;
    exp_rsp.push_back({1'b0, 8'h5C});
    send_cmd(1'b1, 2'd1, 4'h4, 8'h00, 8'h00, 8'h00, 4'h0);
    wait_falls(base + 2);
    repeat (5) tick();
    rx_pulse(8'h5C);
    wait_rdy(1'b1, "t4a");
    base = falls;
    exp_rsp.push_back({1'b1, 8'h5C});
    send_cmd(1'b1, 2'd1, 4'h9, 8'h00, 8'h00, 8'h00, 4'h0);
    wait_falls(base + 2);
    wait_rdy(1'b1, "t4b");
    chk("t4_tmo_lag", 32'(rsp_cyc - fall_cyc), 32'd17);
    chk("t4_rsp_keep", 32'(ib.RSP_DATA), 32'h5C);
    base = falls;
    exp_rsp.push_back({1'b0, 8'h81});
    send_cmd(1'b1, 2'd1, 4'hC, 8'h00, 8'h00, 8'h00, 4'h0);
    wait_falls(base + 2);
    while (cyc < fall_cyc + 16) tick();
    rx_pulse(8'h81);
    chk("t4_last_cycle_lag", 32'(rsp_cyc - fall_cyc), 32'd17);
    wait_rdy(1'b1, "t4c");
    tick();
    chk("t4_last_cycle_data", 32'(ib.RSP_DATA), 32'h81);

    // stray receive strobes while idle and while waiting to send
    rx_pulse(8'hFF);
    tick();
    chk("t5_idle_a", 32'(ia.RSP_DATA), 32'h5A);
    chk("t5_idle_b", 32'(ib.RSP_DATA), 32'h81);
    busy = 1'b1;
    bcnt = 6;
    send_cmd(1'b0, 2'd0, 4'h3, 8'h99, 8'h00, 8'h00, 4'h0);
    rx_pulse(8'hFF);
    wait_rdy(1'b0, "t5");
    chk("t5_send_a", 32'(ia.RSP_DATA), 32'h5A);

    // reset during the second byte of ALU_OPS, then a clean REG_RD
    busy_len = 4;
    base = n_tx;
    send_cmd(1'b0, 2'd2, 4'h0, 8'h00, 8'h55, 8'h66, 4'h7);
    n = 0;
    while (n_tx < base + 2 && n < 200) begin
      tick();
      n++;
    end
    chk("t6_second_byte", 32'(n_tx - base), 32'd2);
    tick();
    rst_n = 1'b0;
    #1;
    chk_reset("t6_reset_a", 1'b0);
    chk_reset("t6_reset_b", 1'b1);
    exp_tx.delete();
    exp_rsp.delete();
    busy = 1'b0;
    bcnt = 0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    base = falls;
    exp_rsp.push_back({1'b0, 8'h33});
    send_cmd(1'b0, 2'd1, 4'hA, 8'h00, 8'h00, 8'h00, 4'h0);
    wait_falls(base + 2);
    repeat (3) tick();
    rx_pulse(8'h33);
    wait_rdy(1'b0, "t6");
    chk("t6_rsp_data", 32'(ia.RSP_DATA), 32'h33);

    repeat (5) tick();
    chk("tx_left", 32'(exp_tx.size()), 32'd0);
    chk("rsp_left", 32'(exp_rsp.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
